// File: rtl/somador_pkg.sv
// somador_pkg
// Shared definitions for the serial adder/subtractor:
//   estado_t  - controller states (idle, adding nibbles, result held)
//   NIBBLE_W  - width of one adder slice
//   OP_SOMA / OP_SUB - encodings of the op input
package somador_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      SOMANDO = 2'd1,
      PRONTO  = 2'd2
   } estado_t;

   localparam int NIBBLE_W = 4;

   localparam logic OP_SOMA = 1'b0;
   localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/somador_serial_if.sv
// somador_serial_if
// Operand/result handshake bundle for somador_serial.
//   in_valid/in_ready  - operand transfer (a, b, cin, op)
//   out_valid/out_ready - result transfer (s, cout, ov)
// Modports: master = producer of operands / consumer of results,
//           slave  = the adder block.
interface somador_serial_if
   import somador_pkg::*;
#(
   parameter int NIBBLES = 4
);
   localparam int W = NIBBLE_W * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
   logic         ov;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, s, cout, ov
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, s, cout, ov
   );

endinterface

// File: rtl/somador4bit.sv
// somador4bit
// Combinational 4-bit slice adder.
//   a, b  in  4  operands
//   cin   in  1  carry-in
//   s     out 4  sum nibble
//   cout  out 4  bit 0 is the carry-out of the slice; bits 3:1 are zero
module somador4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic [3:0] cout
);

   logic [4:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign s     = total[3:0];
   assign cout  = {3'b000, total[4]};

endmodule

// File: rtl/somador_serial.sv
// somador_serial
// Multi-nibble serial adder/subtractor. An operand pair accepted over the
// input handshake is summed one nibble per clock (LSB first) through a single
// somador4bit slice, with the ripple carry kept in carry_reg. The full result,
// carry-out and signed overflow are then held on the output handshake.
//   clk  in  1  clock, rising edge
//   rst  in  1  asynchronous reset, active low
//   bus  slave modport of somador_serial_if (operands in, result out)
module somador_serial
   import somador_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic             clk,
   input  logic             rst,
   somador_serial_if.slave  bus
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   estado_t             estado;
   estado_t             estado_next;
   logic [KW-1:0]       k;
   logic [W-1:0]        a_reg;
   logic [W-1:0]        b_reg;
   logic [NIBBLE_W-1:0] s_reg [NIBBLES];
   logic                carry_reg;
   logic                cout_reg;
   logic                ov_reg;

   logic [NIBBLE_W-1:0] a_nib [NIBBLES];
   logic [NIBBLE_W-1:0] b_nib [NIBBLES];
   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic [3:0]          cout_adder;
   logic                aceita;
   logic                somando;
   logic                ultimo;

   // Only the slice carry (bit 0) feeds the ripple chain.
   logic                unused_cout_hi;
   assign unused_cout_hi = ^cout_adder[3:1];

   // ------------------------------------------------------------------
   // Nibble views of the operand registers and result assembly
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign bus.s[gi*NIBBLE_W +: NIBBLE_W] = s_reg[gi];
   end

   assign nib_a = a_nib[k];
   assign nib_b = b_nib[k];

   somador4bit u_somador4bit (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_reg),
      .s    (nib_s),
      .cout (cout_adder)
   );

   assign aceita  = (estado == OCIOSO) && bus.in_valid;
   assign somando = (estado == SOMANDO);
   assign ultimo  = somando && (k == K_LAST);

   // ------------------------------------------------------------------
   // Controller
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado <= OCIOSO;
      end else begin
         estado <= estado_next;
      end
   end

   always_comb begin
      estado_next   = estado;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (estado)
         OCIOSO: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               estado_next = SOMANDO;
            end
         end
         SOMANDO: begin
            if (k == K_LAST) begin
               estado_next = PRONTO;
            end
         end
         PRONTO: begin
            bus.out_valid = 1'b1;
            // Taking the result only frees the block; a new operand waits
            // for the following edge in OCIOSO.
            if (bus.out_ready) begin
               estado_next = OCIOSO;
            end
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         k         <= '0;
         cout_reg  <= 1'b0;
         ov_reg    <= 1'b0;
      end else if (aceita) begin
         // Subtraction is a + ~b + 1: invert b here and seed the carry.
         a_reg     <= bus.a;
         b_reg     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
         carry_reg <= (bus.op == OP_SUB) ? 1'b1 : bus.cin;
         k         <= '0;
      end else if (somando) begin
         carry_reg <= cout_adder[0];
         if (ultimo) begin
            cout_reg <= cout_adder[0];
            // Overflow: operands of equal sign giving a result of the other
            // sign; b_reg already holds the effective (inverted) operand.
            ov_reg   <= (a_reg[W-1] == b_reg[W-1]) &&
                        (nib_s[NIBBLE_W-1] != a_reg[W-1]);
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_s_reg
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s_reg[gi] <= '0;
         end else if (somando && (k == KW'(gi))) begin
            s_reg[gi] <= nib_s;
         end
      end
   end

   assign bus.cout = cout_reg;
   assign bus.ov   = ov_reg;

endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial
// Directed bench for somador_serial (NIBBLES = 4). Expected results come from
// an integer arithmetic model and are queued when an operand is accepted,
// then popped and compared when out_valid appears.
module tb_somador_serial;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ov;
   } res_t;

   logic clk;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   res_t sb[$];

   somador_serial_if #(.NIBBLES(NIBBLES)) bus ();

   somador_serial #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic res_t modelo(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic op);
      res_t    r;
      longint  ua, ub, us;
      longint  sa, sbv, ss;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (op) begin
         us     = ua - ub;
         ss     = sa - sbv;
         r.cout = (ua >= ub);
      end else begin
         us     = ua + ub + longint'(cin);
         ss     = sa + sbv + longint'(cin);
         r.cout = (us > 65535);
      end
      r.s  = us[W-1:0];
      r.ov = (ss > 32767) || (ss < -32768);
      return r;
   endfunction

   // Called at a negedge with the block idle; returns just after the accept edge.
   task automatic aceitar(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic op, input bit push);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.op       = op;
      bus.in_valid = 1'b1;
      check("in_ready_before_accept", bus.in_ready, 1);
      if (push) sb.push_back(modelo(a, b, cin, op));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      $display("accept a=%h b=%h cin=%0d op=%0d", a, b, cin, op);
   endtask

   // Counts edges after the accept edge until out_valid, then checks the result.
   task automatic esperar(input string tag, output res_t got_exp);
      int   n;
      res_t e;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_latency"}, n, NIBBLES);
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_scoreboard: observed empty required entry", tag);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      check({tag, "_s"},    bus.s,    e.s);
      check({tag, "_cout"}, bus.cout, e.cout);
      check({tag, "_ov"},   bus.ov,   e.ov);
      $display("result %s s=%h cout=%0d ov=%0d exp s=%h cout=%0d ov=%0d",
               tag, bus.s, bus.cout, bus.ov, e.s, e.cout, e.ov);
      got_exp = e;
   endtask

   task automatic consumir(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_out_valid_after_take"}, bus.out_valid, 0);
      check({tag, "_in_ready_after_take"},  bus.in_ready,  1);
   endtask

   initial begin
      res_t e;
      res_t held;
      int   stray;

      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.op        = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_s",         bus.s,         0);
      check("rst_cout",      bus.cout,      0);
      check("rst_ov",        bus.ov,        0);
      rst = 1'b1;
      @(negedge clk);

      // Directed arithmetic cases
      aceitar(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      esperar("add_wrap", e);
      check("add_wrap_s_const", bus.s, 32'h0000);
      consumir("add_wrap");

      aceitar(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
      esperar("add_ov", e);
      check("add_ov_s_const", bus.s, 32'h8000);
      consumir("add_ov");

      aceitar(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
      esperar("sub_neg", e);
      check("sub_neg_s_const", bus.s, 32'hFFFE);
      consumir("sub_neg");

      aceitar(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
      esperar("sub_ov", e);
      check("sub_ov_s_const", bus.s, 32'h7FFF);
      consumir("sub_ov");

      // Random mix
      for (int i = 0; i < 6; i++) begin
         aceitar(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         esperar("rand", e);
         consumir("rand");
      end

      // Backpressure with operands offered while the result is held
      aceitar(16'h9ABC, 16'h8765, 1'b1, 1'b0, 1'b1);
      esperar("bp", held);
      for (int i = 0; i < 3; i++) begin
         bus.a        = W'($urandom);
         bus.b        = W'($urandom);
         bus.op       = 1'($urandom);
         bus.in_valid = 1'b1;
         @(negedge clk);
         check("bp_out_valid_hold", bus.out_valid, 1);
         check("bp_in_ready_low",   bus.in_ready,  0);
         check("bp_s_stable",       bus.s,         held.s);
         check("bp_cout_stable",    bus.cout,      held.cout);
         check("bp_ov_stable",      bus.ov,        held.ov);
      end
      // Take the result with in_valid still high: no capture on that edge.
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_idle_out_valid", bus.out_valid, 0);
      check("bp_idle_in_ready",  bus.in_ready,  1);
      aceitar(16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b1);
      esperar("bp_next", e);
      consumir("bp_next");

      // Reset in the middle of an operation (k == 2)
      aceitar(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready",  bus.in_ready,  1);
      check("midrst_s",         bus.s,         0);
      check("midrst_cout",      bus.cout,      0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid) stray++;
      end
      check("midrst_no_pulse", stray, 0);
      aceitar(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
      esperar("after_rst", e);
      check("after_rst_s_const", bus.s, 32'h2345);
      consumir("after_rst");

      check("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
